// File: rtl/tiger_mem_arbiter.sv
// tiger_mem_arbiter: N-master to 1-slave Avalon-MM arbiter for the Tiger memory
// subsystem. It supports round-robin or fixed-priority arbitration and locks a
// stalled grant until the slave accepts it. While checkpointing is high, only the
// checkpoint master receives new grants. Read IDs are tracked in order so
// readdatavalid can be routed back to the master that issued the read.
module tiger_mem_arbiter #(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MAX_PEND    = 4,
    parameter int PRIO_MODE   = 0,
    parameter int CHPT_MASTER = 1
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            checkpointing,
    input  logic [NUM_MASTERS-1:0]          m_read,
    input  logic [NUM_MASTERS-1:0]          m_write,
    input  logic [NUM_MASTERS*ADDR_W-1:0]   m_address,
    input  logic [NUM_MASTERS*DATA_W-1:0]   m_writedata,
    input  logic [NUM_MASTERS*DATA_W/8-1:0] m_byteenable,
    output logic [NUM_MASTERS-1:0]          m_waitrequest,
    output logic [DATA_W-1:0]               m_readdata,
    output logic [NUM_MASTERS-1:0]          m_readdatavalid,
    output logic                            s_read,
    output logic                            s_write,
    output logic [ADDR_W-1:0]               s_address,
    output logic [DATA_W-1:0]               s_writedata,
    output logic [DATA_W/8-1:0]             s_byteenable,
    input  logic [DATA_W-1:0]               s_readdata,
    input  logic                            s_waitrequest,
    input  logic                            s_readdatavalid,
    output logic [$clog2(MAX_PEND):0]       pend_count,
    output logic                            rd_err
);

    localparam int GW   = $clog2(NUM_MASTERS);
    localparam int PW   = $clog2(MAX_PEND);
    localparam int CW   = PW + 1;
    localparam int BE_W = DATA_W / 8;

    logic                   lock_valid_q, lock_valid_d;
    logic [GW-1:0]          lock_id_q, lock_id_d;
    logic [GW-1:0]          rr_ptr_q, rr_ptr_d;
    logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]          count_q, count_d;
    logic                   rd_err_q, rd_err_d;
    logic [GW-1:0]          fifo_q [MAX_PEND];

    logic [NUM_MASTERS-1:0] eligible;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   arb_valid;
    logic [GW-1:0]          arb_id;
    logic                   grant_valid;
    logic [GW-1:0]          grant_id;
    logic                   accept;
    logic                   push;
    logic                   pop;

    assign fifo_full  = (count_q == CW'(MAX_PEND));
    assign fifo_empty = (count_q == '0);

    // A master may compete if it requests, passes the checkpoint gate, and (for reads) an ID slot is free
    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            eligible[i] = (m_read[i] | m_write[i])
                        & (!checkpointing | (i == CHPT_MASTER))
                        & (!m_read[i] | !fifo_full);
        end
    end

    // Pick a winner among eligible masters; loops run high-to-low so the preferred candidate is written last
    always_comb begin
        logic [GW:0] cand;
        arb_valid = 1'b0;
        arb_id    = '0;
        cand      = '0;
        if (PRIO_MODE == 1) begin
            for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
                if (eligible[i]) begin
                    arb_valid = 1'b1;
                    arb_id    = GW'(i);
                end
            end
        end else begin
            for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
                cand = {1'b0, rr_ptr_q} + (GW + 1)'(k);
                if (cand >= (GW + 1)'(NUM_MASTERS)) begin
                    cand = cand - (GW + 1)'(NUM_MASTERS);
                end
                if (eligible[cand[GW-1:0]]) begin
                    arb_valid = 1'b1;
                    arb_id    = cand[GW-1:0];
                end
            end
        end
    end

    // A held lock overrides arbitration, so a stalled request keeps the slave port until accepted
    always_comb begin
        grant_valid = lock_valid_q | arb_valid;
        grant_id    = lock_valid_q ? lock_id_q : arb_id;
    end

    // Route the granted master onto the slave port and stall every other master
    always_comb begin
        s_read        = grant_valid & m_read[grant_id];
        s_write       = grant_valid & m_write[grant_id];
        s_address     = m_address[int'(grant_id) * ADDR_W +: ADDR_W];
        s_writedata   = m_writedata[int'(grant_id) * DATA_W +: DATA_W];
        s_byteenable  = m_byteenable[int'(grant_id) * BE_W +: BE_W];
        m_waitrequest = '1;
        if (grant_valid) begin
            m_waitrequest[grant_id] = s_waitrequest;
        end
    end

    assign accept = (s_read | s_write) & !s_waitrequest;
    assign push   = accept & s_read;
    assign pop    = s_readdatavalid & !fifo_empty;

    // Return read data to the master whose ID sits at the head of the pending FIFO
    always_comb begin
        m_readdata      = s_readdata;
        m_readdatavalid = '0;
        if (pop) begin
            m_readdatavalid[fifo_q[rd_ptr_q]] = 1'b1;
        end
    end

    // Next-state for lock, round-robin pointer, ID FIFO pointers/count and the sticky error flag
    always_comb begin
        lock_valid_d = (s_read | s_write) & s_waitrequest;
        lock_id_d    = lock_valid_d ? grant_id : lock_id_q;
        rr_ptr_d     = rr_ptr_q;
        if (accept) begin
            rr_ptr_d = (int'(grant_id) == NUM_MASTERS - 1) ? '0 : grant_id + GW'(1);
        end
        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
        rd_err_d = rd_err_q | (s_readdatavalid & fifo_empty);
    end

    // Control state register; reset discards every pending read ID
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lock_valid_q <= 1'b0;
            lock_id_q    <= '0;
            rr_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            rd_err_q     <= 1'b0;
        end else begin
            lock_valid_q <= lock_valid_d;
            lock_id_q    <= lock_id_d;
            rr_ptr_q     <= rr_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            rd_err_q     <= rd_err_d;
        end
    end

    // ID storage needs no reset because the count qualifies every entry
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= grant_id;
        end
    end

    assign pend_count = count_q;
    assign rd_err     = rd_err_q;

endmodule

// File: doc/tiger_mem_arbiter.md
# tiger_mem_arbiter

Parametrised N-master to 1-slave Avalon-MM arbiter for the Tiger memory subsystem. It sits between the per-master caches (instruction, data, and future masters such as a DMA or checkpoint engine) and a single shared memory port, replacing separate instruction/data masters. It supports pipelined reads with up to MAX_PEND outstanding, selectable round-robin or fixed priority, and checkpoint-aware arbitration that restricts grants to the checkpoint master while a checkpoint is in progress.

## Interface
- NUM_MASTERS, 2: number of upstream masters (2..8); master index i occupies slice i of every packed bus.
- ADDR_W, 32: address width.
- DATA_W, 32: data width; byteenable width is DATA_W/8.
- MAX_PEND, 4: maximum outstanding reads (power of two, 2..16).
- PRIO_MODE, 0: 0 = round-robin, 1 = fixed priority (lowest index wins).
- CHPT_MASTER, 1: master allowed new grants while checkpointing is high.
- clk  in  1  clock; all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- checkpointing  in  1  checkpoint in progress.
- m_read, m_write  in  NUM_MASTERS  per-master request strobes.
- m_address  in  NUM_MASTERS*ADDR_W  per-master address.
- m_writedata  in  NUM_MASTERS*DATA_W  per-master write data.
- m_byteenable  in  NUM_MASTERS*DATA_W/8  per-master byte enables.
- m_waitrequest  out  NUM_MASTERS  per-master stall.
- m_readdata  out  DATA_W  shared read data (s_readdata passthrough).
- m_readdatavalid  out  NUM_MASTERS  per-master read-data strobe.
- s_read, s_write  out  1  slave request strobes.
- s_address, s_writedata, s_byteenable  out  ADDR_W, DATA_W, DATA_W/8  slave request fields.
- s_readdata  in  DATA_W; s_waitrequest  in  1; s_readdatavalid  in  1.
- pend_count  out  $clog2(MAX_PEND)+1  outstanding reads.
- rd_err  out  1  sticky: readdatavalid received with no read pending.

## Operation
- Requester i is eligible when (m_read[i] | m_write[i]), checkpointing is low or i == CHPT_MASTER, and, for a read, pend_count < MAX_PEND. A full pend FIFO blocks reads even if s_readdatavalid pops in the same cycle; writes still proceed.
- Lock register {lock_valid, lock_id}: when lock_valid is set, grant = lock_id regardless of eligibility or checkpointing. Otherwise grant goes to the arbitration winner among eligible masters.
- Round-robin: search starts at rr_ptr, wraps modulo NUM_MASTERS; rr_ptr <= grant+1 (wrapped) on each accepted transfer. Fixed priority: lowest eligible index wins; rr_ptr is unused.
- The granted master's fields drive s_*; s_read/s_write = granted master's strobes. m_waitrequest[grant] = s_waitrequest; all other bits = 1. With no grant: s_read = s_write = 0 and all m_waitrequest = 1.
- Accept = (s_read | s_write) & !s_waitrequest. A granted, unaccepted request sets lock_valid/lock_id; accept clears lock_valid.
- Accepted read pushes grant index into the ID FIFO (depth MAX_PEND). s_readdatavalid pops the head; m_readdatavalid[head] = 1 in the same cycle. Simultaneous push and pop leaves pend_count unchanged.
- s_readdatavalid with the FIFO empty: no m_readdatavalid, rd_err <= 1 (cleared only by reset).
- Writes are not tracked in the FIFO.

## Timing
- Request path and readdatavalid routing are combinational (zero added latency). Grant, lock, rr_ptr, FIFO and rd_err are registered.
- Reset (asynchronous assert, synchronous release): lock_valid=0, rr_ptr=0, FIFO empty, pend_count=0, rd_err=0. Consequently s_read=s_write=0, m_waitrequest all 1, m_readdatavalid all 0.
- Reset mid-transfer drops all pending IDs. Any readdatavalid arriving afterwards sets rd_err.
- A rise of checkpointing does not break an existing lock. The locked transfer completes first; only CHPT_MASTER is granted afterwards.
- Back-to-back accepts from different masters are allowed on consecutive cycles.

## Test plan
- RR fairness: NUM_MASTERS=3, all assert m_read every cycle, s_waitrequest=0 -> grants 0,1,2,0,1,2; each m_readdatavalid[i] returns in issue order with a fixed 3-cycle slave latency.
- Lock: master 0 writes, s_waitrequest=1 for 4 cycles while master 1 requests -> s_address stays master 0's for 4 cycles; master 1 is granted in cycle 5.
- Pend limit: MAX_PEND=4, slave withholds readdatavalid -> 4 reads accepted, the 5th read is held (pend_count=4) while a concurrent write from another master is accepted; one readdatavalid -> pend_count=3 and the read is granted next cycle.
- Checkpoint: checkpointing=1, CHPT_MASTER=1, masters 0 and 1 request -> only master 1 is granted; master 0 waitrequest=1 until checkpointing=0.
- Fixed priority: PRIO_MODE=1, masters 1 and 2 request, then master 0 joins -> 1,1,...,0 immediately once it is eligible.
- Error and reset: pulse s_readdatavalid with no pending read -> rd_err=1, no m_readdatavalid. Assert reset_n=0 with 2 reads pending -> pend_count=0 and rd_err=0 asynchronously.
